// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sram_arb_pkg
//  Description : Shared types and constants for the SRAM port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  // Which requester owns (or last owned) the SRAM port
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  // Width of the ACCESS-phase wait counter and the largest count it holds
  localparam int WAIT_CNT_W      = 4;
  localparam int WAIT_STATES_MAX = 15;

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr2
//  Description : Combinational 2-way round-robin picker. req[0] is the fetch
//                requester, req[1] the load/store requester. On a tie the
//                requester that did not own the port last time wins.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_rr2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last_owner,
  output arb_owner_t grant_owner,
  output logic       grant_valid
);

  // Single requester wins outright; a tie goes to whoever was not last owner
  always_comb begin
    grant_valid = |req;
    grant_owner = OWN_IF;
    if (req[0] && req[1]) begin
      grant_owner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
    end else if (req[1]) begin
      grant_owner = OWN_LS;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Shares the single SRAM/mem2IO port between the fetch (IF)
//                and load/store (LS) requesters. Round-robin arbitration,
//                req/valid handshake per requester and WAIT_STATES extra
//                ACCESS cycles per transaction.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  // fetch requester (read only)
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store requester
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  // SRAM / mem2IO side
  output logic [ADDR_W-1:0] ADDR,
  output logic              OE,
  output logic              WE,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              busy
);

  // Reject an out-of-range wait-state count at elaboration
  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_wait_states_check
    $error("sram_port_arbiter: WAIT_STATES must be in 0..15");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  arb_owner_t              r_owner;
  arb_owner_t              r_last_owner;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt;
  logic                    r_we_pend;
  arb_owner_t              w_grant_owner;
  logic                    w_grant_valid;
  logic                    w_first_cycle;
  logic                    w_last_cycle;

  arb_rr2 u_arb_rr2 (
    .req         ({ls_req, if_req}),
    .last_owner  (r_last_owner),
    .grant_owner (w_grant_owner),
    .grant_valid (w_grant_valid)
  );

  // The counter is loaded with WAIT_LOAD at grant and counts down to zero
  assign w_first_cycle = (r_wait_cnt == WAIT_LOAD);
  assign w_last_cycle  = (r_wait_cnt == '0);

  // State register; reset aborts any transaction immediately
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus strobes and pulses decoded from the current phase
  always_comb begin
    w_state_nxt = r_state;
    OE          = 1'b0;
    WE          = 1'b0;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    if_valid    = 1'b0;
    ls_valid    = 1'b0;
    busy        = (r_state != ARB_IDLE);
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        OE = ~r_we_pend;
        WE = r_we_pend;
        if (w_first_cycle) begin
          if_gnt = (r_owner == OWN_IF);
          ls_gnt = (r_owner == OWN_LS);
        end
        if (w_last_cycle) begin
          w_state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: begin
        if_valid    = (r_owner == OWN_IF);
        ls_valid    = (r_owner == OWN_LS);
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Grant-time capture of the SRAM request, wait counting, read-data capture
  // and round-robin history. Data_to_SRAM only follows LS grants, since the
  // fetch side has no write data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_owner      <= OWN_IF;
      r_last_owner <= OWN_LS;
      r_wait_cnt   <= '0;
      r_we_pend    <= 1'b0;
      ADDR         <= '0;
      Data_to_SRAM <= '0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_owner    <= w_grant_owner;
            r_wait_cnt <= WAIT_LOAD;
            if (w_grant_owner == OWN_IF) begin
              ADDR      <= if_addr;
              r_we_pend <= 1'b0;
            end else begin
              ADDR         <= ls_addr;
              r_we_pend    <= ls_we;
              Data_to_SRAM <= ls_wdata;
            end
          end
        end
        ARB_ACCESS: begin
          if (w_last_cycle) begin
            if (!r_we_pend) begin
              if (r_owner == OWN_IF) begin
                if_rdata <= Data_from_SRAM;
              end else begin
                ls_rdata <= Data_from_SRAM;
              end
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
          end
        end
        ARB_DONE: begin
          r_last_owner <= r_owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Self-checking bench for sram_port_arbiter. Two instances:
//                u_dut_ws1 (WAIT_STATES=1) and u_dut_ws0 (WAIT_STATES=0)
//                share the requester inputs; directed scenarios plus a
//                randomized run checked against a transaction-timeline model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;

  logic        a_if_gnt, a_if_valid, a_ls_gnt, a_ls_valid, a_OE, a_WE, a_busy;
  logic [31:0] a_if_rdata, a_ls_rdata, a_ADDR, a_dts, a_dfs;
  logic        b_if_gnt, b_if_valid, b_ls_gnt, b_ls_valid, b_OE, b_WE, b_busy;
  logic [31:0] b_if_rdata, b_ls_rdata, b_ADDR, b_dts, b_dfs;

  int checks   = 0;
  int failures = 0;
  bit sel      = 1'b0;   // 0: observe WAIT_STATES=1 instance, 1: WAIT_STATES=0

  always #5 clk = ~clk;

  // SRAM contents as a pure function of address
  function automatic logic [31:0] sram_f(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign a_dfs = sram_f(a_ADDR);
  assign b_dfs = sram_f(b_ADDR);

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(1)) u_dut_ws1 (
    .Clk(clk), .Reset_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_valid(a_if_valid), .if_rdata(a_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(a_ls_gnt), .ls_valid(a_ls_valid), .ls_rdata(a_ls_rdata),
    .ADDR(a_ADDR), .OE(a_OE), .WE(a_WE), .Data_to_SRAM(a_dts), .Data_from_SRAM(a_dfs), .busy(a_busy)
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) u_dut_ws0 (
    .Clk(clk), .Reset_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(b_ls_gnt), .ls_valid(b_ls_valid), .ls_rdata(b_ls_rdata),
    .ADDR(b_ADDR), .OE(b_OE), .WE(b_WE), .Data_to_SRAM(b_dts), .Data_from_SRAM(b_dfs), .busy(b_busy)
  );

  // Control vector order: {if_gnt, ls_gnt, if_valid, ls_valid, OE, WE, busy}
  wire [6:0]  a_ctrl = {a_if_gnt, a_ls_gnt, a_if_valid, a_ls_valid, a_OE, a_WE, a_busy};
  wire [6:0]  b_ctrl = {b_if_gnt, b_ls_gnt, b_if_valid, b_ls_valid, b_OE, b_WE, b_busy};
  wire [6:0]  s_ctrl     = sel ? b_ctrl     : a_ctrl;
  wire [31:0] s_ADDR     = sel ? b_ADDR     : a_ADDR;
  wire [31:0] s_dts      = sel ? b_dts      : a_dts;
  wire [31:0] s_if_rdata = sel ? b_if_rdata : a_if_rdata;
  wire [31:0] s_ls_rdata = sel ? b_ls_rdata : a_ls_rdata;

  task automatic clear_inputs();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    @(negedge clk);
    checks++; if (a_ctrl !== 7'b0) begin failures++; $display("FAIL reset_ctrl_ws1 got=%b exp=0000000", a_ctrl); end
    checks++; if ({a_ADDR, a_dts, a_if_rdata, a_ls_rdata} !== 128'b0) begin failures++;
      $display("FAIL reset_data_ws1 got=%h/%h/%h/%h exp=0", a_ADDR, a_dts, a_if_rdata, a_ls_rdata); end
    checks++; if (b_ctrl !== 7'b0) begin failures++; $display("FAIL reset_ctrl_ws0 got=%b exp=0000000", b_ctrl); end
    checks++; if ({b_ADDR, b_dts, b_if_rdata, b_ls_rdata} !== 128'b0) begin failures++;
      $display("FAIL reset_data_ws0 got=%h/%h/%h/%h exp=0", b_ADDR, b_dts, b_if_rdata, b_ls_rdata); end
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_ctrl !== 7'b0) begin failures++; $display("FAIL reset_idle got=%b exp=0000000", a_ctrl); end
  endtask

  // IF read at WAIT_STATES=1: gnt at 1, OE over 1..2, valid at 3
  task automatic test_if_read();
    logic [6:0] exp_c [4];
    exp_c = '{7'b1000101, 7'b0000101, 7'b0010001, 7'b0000000};
    sel = 1'b0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      checks++; if (s_ctrl !== exp_c[cyc-1]) begin failures++;
        $display("FAIL if_read_ctrl cyc=%0d got=%b exp=%b", cyc, s_ctrl, exp_c[cyc-1]); end
      if (cyc <= 2) begin
        checks++; if (s_ADDR !== 32'h10) begin failures++; $display("FAIL if_read_addr cyc=%0d got=%h exp=00000010", cyc, s_ADDR); end
      end
      if (cyc == 3) begin
        checks++; if (s_if_rdata !== 32'h1234_5678) begin failures++;
          $display("FAIL if_read_rdata got=%h exp=12345678", s_if_rdata); end
        if_req = 1'b0;
      end
    end
  endtask

  // LS store: WE for two cycles, address/data latched at grant and held
  task automatic test_ls_store();
    logic [6:0] exp_c [4];
    exp_c = '{7'b0100011, 7'b0000011, 7'b0001001, 7'b0000000};
    sel = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0100; ls_wdata = 32'hDEAD_BEEF;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      checks++; if (s_ctrl !== exp_c[cyc-1]) begin failures++;
        $display("FAIL ls_store_ctrl cyc=%0d got=%b exp=%b", cyc, s_ctrl, exp_c[cyc-1]); end
      if (cyc <= 3) begin
        checks++; if ({s_ADDR, s_dts} !== {32'h100, 32'hDEAD_BEEF}) begin failures++;
          $display("FAIL ls_store_bus cyc=%0d got=%h/%h exp=00000100/deadbeef", cyc, s_ADDR, s_dts); end
      end
      if (cyc == 1) begin
        ls_addr = $urandom; ls_wdata = $urandom;
      end
      if (cyc == 3) begin
        checks++; if (s_ls_rdata !== 32'h0) begin failures++; $display("FAIL ls_store_rdata got=%h exp=00000000", s_ls_rdata); end
        ls_req = 1'b0; ls_we = 1'b0;
      end
    end
  endtask

  // Both requesters held high from reset: strict IF/LS alternation
  task automatic test_alternate();
    bit order[$];
    sel = 1'b0;
    do_reset();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    if_addr = 32'h0000_0200; ls_addr = 32'h0000_0300;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      checks++; if ($countones(s_ctrl[6:3]) > 1) begin failures++;
        $display("FAIL alt_overlap cyc=%0d got=%b exp=at_most_one", cyc, s_ctrl[6:3]); end
      if (s_ctrl[6]) order.push_back(1'b0);
      if (s_ctrl[5]) order.push_back(1'b1);
    end
    if_req = 1'b0; ls_req = 1'b0;
    checks++; if (order.size() != 4) begin failures++; $display("FAIL alt_count got=%0d exp=4", order.size()); end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      checks++; if (order[i] !== i[0]) begin failures++; $display("FAIL alt_order idx=%0d got=%b exp=%b", i, order[i], i[0]); end
    end
    checks++; if (s_ls_rdata !== sram_f(32'h300)) begin failures++;
      $display("FAIL alt_ls_rdata got=%h exp=%h", s_ls_rdata, sram_f(32'h300)); end
    repeat (4) @(negedge clk);
  endtask

  // Reset during a store's ACCESS phase: WE drops at once, no valid, recovery
  task automatic test_reset_mid();
    sel = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0400; ls_wdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if (s_ctrl !== 7'b0100011) begin failures++; $display("FAIL rmid_pre got=%b exp=0100011", s_ctrl); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s_ctrl !== 7'b0) begin failures++; $display("FAIL rmid_async got=%b exp=0000000", s_ctrl); end
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_ctrl !== 7'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0000000", s_ctrl); end
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    checks++; if (s_ctrl !== 7'b1000101) begin failures++; $display("FAIL rmid_gnt got=%b exp=1000101", s_ctrl); end
    repeat (2) @(negedge clk);
    checks++; if (s_ctrl !== 7'b0010001 || s_if_rdata !== 32'h1234_5678) begin failures++;
      $display("FAIL rmid_valid got=%b/%h exp=0010001/12345678", s_ctrl, s_if_rdata); end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Dropping IF req after grant still completes; LS withdrawn before grant never served
  task automatic test_req_drop();
    logic [6:0] exp_c [7];
    exp_c = '{7'b1000101, 7'b0000101, 7'b0010001, 7'b0, 7'b0, 7'b0, 7'b0};
    sel = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0020;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      checks++; if (s_ctrl !== exp_c[cyc-1]) begin failures++;
        $display("FAIL drop_ctrl cyc=%0d got=%b exp=%b", cyc, s_ctrl, exp_c[cyc-1]); end
      if (cyc == 1) begin
        if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0040;
      end
      if (cyc == 2) ls_req = 1'b0;
      if (cyc == 3) begin
        checks++; if (s_if_rdata !== sram_f(32'h20)) begin failures++;
          $display("FAIL drop_rdata got=%h exp=%h", s_if_rdata, sram_f(32'h20)); end
      end
    end
  endtask

  // WAIT_STATES=0 back-to-back LS loads: valid at 2, second gnt at 4
  task automatic test_back_to_back();
    logic [6:0]  exp_c [6];
    logic [31:0] fa, fb, exp_rd;
    exp_c = '{7'b0100101, 7'b0001001, 7'b0000000, 7'b0100101, 7'b0001001, 7'b0000000};
    fa = sram_f(32'h0000_1000);
    fb = sram_f(32'h0000_2000);
    sel = 1'b1;
    do_reset();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_1000;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      exp_rd = (cyc < 2) ? 32'h0 : (cyc < 5) ? fa : fb;
      checks++; if (s_ctrl !== exp_c[cyc-1]) begin failures++;
        $display("FAIL b2b_ctrl cyc=%0d got=%b exp=%b", cyc, s_ctrl, exp_c[cyc-1]); end
      checks++; if (s_ls_rdata !== exp_rd) begin failures++;
        $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", cyc, s_ls_rdata, exp_rd); end
      if (cyc == 2) ls_addr = 32'h0000_2000;
      if (cyc == 5) ls_req = 1'b0;
    end
  endtask

  // Random traffic against a transaction-timeline model: a transaction decided
  // in cycle d shows gnt at d+1, strobes over d+1..d+ws+1, valid at d+ws+2 and
  // frees the port for a new decision at d+ws+3.
  task automatic test_random(input bit which, input int ws, input int ncyc);
    bit          act = 1'b0, own = 1'b0, last = 1'b1, m_we = 1'b0;
    int          d = 0, k;
    logic [31:0] m_addr = '0, e_dts = '0, e_ifrd = '0, e_lsrd = '0;
    bit          if_live = 1'b0, if_g = 1'b0, ls_live = 1'b0, ls_g = 1'b0;
    bit          ev_if, ev_ls, in_acc;
    logic [6:0]  e_ctrl;
    sel = which;
    do_reset();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      k = c - d;
      if (act && k >= ws + 3) act = 1'b0;
      ev_if  = act && (k == ws + 2) && !own;
      ev_ls  = act && (k == ws + 2) && own;
      in_acc = act && (k >= 1) && (k <= ws + 1);
      e_ctrl = {act && k == 1 && !own, act && k == 1 && own, ev_if, ev_ls,
                in_acc && !m_we, in_acc && m_we, act && k >= 1 && k <= ws + 2};
      if (ev_if) e_ifrd = sram_f(m_addr);
      if (ev_ls && !m_we) e_lsrd = sram_f(m_addr);
      checks++; if (s_ctrl !== e_ctrl) begin failures++;
        $display("FAIL rnd_ctrl ws=%0d cyc=%0d got=%b exp=%b", ws, c, s_ctrl, e_ctrl); end
      checks++; if (s_ADDR !== m_addr) begin failures++;
        $display("FAIL rnd_addr ws=%0d cyc=%0d got=%h exp=%h", ws, c, s_ADDR, m_addr); end
      checks++; if (s_dts !== e_dts) begin failures++;
        $display("FAIL rnd_wdata ws=%0d cyc=%0d got=%h exp=%h", ws, c, s_dts, e_dts); end
      checks++; if ({s_if_rdata, s_ls_rdata} !== {e_ifrd, e_lsrd}) begin failures++;
        $display("FAIL rnd_rdata ws=%0d cyc=%0d got=%h/%h exp=%h/%h", ws, c, s_if_rdata, s_ls_rdata, e_ifrd, e_lsrd); end
      // fetch requester behaviour
      if (if_live && !if_g) begin
        if ($urandom_range(0, 7) == 0) if_live = 1'b0;
      end else if (if_live && if_g) begin
        if (ev_if) begin if_live = 1'b0; if_g = 1'b0; end
        else if ($urandom_range(0, 3) == 0) if_req = 1'b0;
      end
      if (!if_live) begin
        if ($urandom_range(0, 1) == 1) begin if_live = 1'b1; if_req = 1'b1; if_addr = $urandom; end
        else if_req = 1'b0;
      end
      // load/store requester behaviour
      if (ls_live && !ls_g) begin
        if ($urandom_range(0, 7) == 0) ls_live = 1'b0;
      end else if (ls_live && ls_g) begin
        if (ev_ls) begin ls_live = 1'b0; ls_g = 1'b0; end
        else if ($urandom_range(0, 3) == 0) ls_req = 1'b0;
      end
      if (!ls_live) begin
        if ($urandom_range(0, 1) == 1) begin
          ls_live = 1'b1; ls_req = 1'b1; ls_addr = $urandom; ls_wdata = $urandom; ls_we = $urandom_range(0, 1);
        end else ls_req = 1'b0;
      end
      // arbitration decision for the port when free
      if (!act && (if_req || ls_req)) begin
        own  = (if_req && ls_req) ? !last : ls_req;
        last = own; act = 1'b1; d = c;
        if (!own) begin m_addr = if_addr; m_we = 1'b0; if_g = 1'b1; end
        else begin m_addr = ls_addr; m_we = ls_we; e_dts = ls_wdata; ls_g = 1'b1; end
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_if_read();
    test_ls_store();
    test_alternate();
    test_reset_mid();
    test_req_drop();
    test_back_to_back();
    test_random(1'b0, 1, 400);
    test_random(1'b1, 0, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
